reloj_hhmmss_cfg: RTL
=====================

RELOJ_HHMMSS_CFG -- requirements
Module: reloj_hhmmss_cfg

Interface
REQ-001 SHALL have parameter HOURS_MOD, default 24, meaning hour modulus (12 or 24 only).
REQ-002 SHALL have parameter MINS_MOD, default 60, meaning minute modulus.
REQ-003 SHALL have parameter SECS_MOD, default 60, meaning second modulus.
REQ-004 SHALL have parameters HW=5, MW=6, SW=6, meaning widths of hour, minute and second fields.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port tick  input  1  one-cycle-per-second enable, synchronous to clk.
REQ-008 SHALL have port hold  input  1  level; 1 = pause counting (HOLD state).
REQ-009 SHALL have port inc_h / inc_m  input  1 each  single-cycle step pulses, honoured only in HOLD.
REQ-010 SHALL have port set_valid  input  1  load request.
REQ-011 SHALL have port set_horas/set_minutos/set_segundos  input  HW/MW/SW  load value.
REQ-012 SHALL have port set_ready  output  1  load accepted when set_valid&&set_ready.
REQ-013 SHALL have port set_err  output  1  one-cycle pulse: load rejected.
REQ-014 SHALL have port horas/minutos/segundos  output  HW/MW/SW  current time.
REQ-015 SHALL have port hora12  output  HW  display hour 1..12; pm  output  1  afternoon flag.
REQ-016 SHALL have port day_pulse  output  1  one-cycle pulse on full-day wrap.

Function
REQ-017 SHALL implement two states, RUN and HOLD; hold=1 -> HOLD next cycle, hold=0 -> RUN next cycle.
REQ-018 In RUN, tick=1 SHALL increment segundos; at SECS_MOD-1 wrap to 0 and carry to minutos; at MINS_MOD-1 wrap and carry to horas; at HOURS_MOD-1 wrap to 0.
REQ-019 Counter updates SHALL be visible on outputs the cycle after the tick edge (1-cycle latency).
REQ-020 day_pulse SHALL assert for exactly one cycle, same cycle outputs show 00:00:00 after wrap from max.
REQ-021 In HOLD, tick SHALL be ignored; segundos frozen.
REQ-022 In HOLD, inc_m SHALL increment minutos mod MINS_MOD with no carry to horas and SHALL clear segundos to 0.
REQ-023 In HOLD, inc_h SHALL increment horas mod HOURS_MOD; inc_h and inc_m together SHALL apply both.
REQ-024 inc_h/inc_m in RUN SHALL be ignored; step wrap SHALL NOT assert day_pulse.
REQ-025 set_ready SHALL be 1 whenever reset=0 (both states); 0 during reset.
REQ-026 Accepted load with all fields in range (h<HOURS_MOD, m<MINS_MOD, s<SECS_MOD) SHALL replace all three fields, visible next cycle.
REQ-027 Accepted load with any field out of range SHALL leave time unchanged and pulse set_err for one cycle.
REQ-028 Valid load SHALL take priority over a simultaneous tick or inc pulse; that tick/inc is discarded, no day_pulse.
REQ-029 Load SHALL NOT change state (RUN/HOLD).
REQ-030 If HOURS_MOD=24: pm = (horas>=12); hora12 = horas mod 12, with 0 shown as 12.
REQ-031 If HOURS_MOD=12: hora12 = horas, with 0 shown as 12; pm = 0.
REQ-032 hora12 and pm SHALL be combinational from registered horas (no added latency).

Reset
REQ-033 reset=1 at clk edge SHALL set horas=minutos=segundos=0, state=RUN, set_err=0, day_pulse=0.
REQ-034 reset SHALL override tick, hold, inc and load in the same cycle; mid-count reset leaves 00:00:00.
REQ-035 After reset, hora12=12, pm=0, set_ready=1 from the first cycle reset=0.

Verification
REQ-036 Reset, load 23:59:58, two ticks in RUN -> 23:59:59, then 00:00:00 with day_pulse high exactly one cycle.
REQ-037 Load 10:59:59, hold=1, 5 ticks -> time stays 10:59:59; inc_m -> 10:00:00; inc_h x14 -> 00:00:00, no day_pulse.
REQ-038 Load h=24,m=0,s=0 (HOURS_MOD=24) -> set_err one cycle, time unchanged; load 13:05:07 -> hora12=1, pm=1.
REQ-039 Load 05:06:07 same cycle as tick -> next cycle 05:06:07 exactly (tick discarded).
REQ-040 Running at 12:34:56, assert reset one cycle with tick and set_valid high -> 00:00:00, RUN, set_err=0.
REQ-041 HOURS_MOD=12, MINS_MOD=4, SECS_MOD=2 instance: from 11:03:01 one tick -> 00:00:00, day_pulse, hora12=12, pm=0.

Source files
------------

// File: rtl/reloj_hhmmss_cfg.sv
// hh:mm:ss time-of-day counter with RUN/HOLD modes, manual hour/minute stepping,
// and a range-checked load port. The 12-hour display view is derived combinationally.
module reloj_hhmmss_cfg #(
    parameter int HOURS_MOD = 24,
    parameter int MINS_MOD  = 60,
    parameter int SECS_MOD  = 60,
    parameter int HW        = 5,
    parameter int MW        = 6,
    parameter int SW        = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          hold,
    input  logic          inc_h,
    input  logic          inc_m,
    input  logic          set_valid,
    input  logic [HW-1:0] set_horas,
    input  logic [MW-1:0] set_minutos,
    input  logic [SW-1:0] set_segundos,
    output logic          set_ready,
    output logic          set_err,
    output logic [HW-1:0] horas,
    output logic [MW-1:0] minutos,
    output logic [SW-1:0] segundos,
    output logic [HW-1:0] hora12,
    output logic          pm,
    output logic          day_pulse
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
    state_t state;

    localparam logic [HW-1:0] H_MAX = HW'(HOURS_MOD - 1);
    localparam logic [MW-1:0] M_MAX = MW'(MINS_MOD - 1);
    localparam logic [SW-1:0] S_MAX = SW'(SECS_MOD - 1);

    logic load_ok, s_wrap, m_wrap, h_wrap;

    assign load_ok   = (set_horas <= H_MAX) && (set_minutos <= M_MAX) && (set_segundos <= S_MAX);
    assign s_wrap    = (segundos == S_MAX);
    assign m_wrap    = (minutos == M_MAX);
    assign h_wrap    = (horas == H_MAX);
    assign set_ready = ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            horas     <= '0;
            minutos   <= '0;
            segundos  <= '0;
            set_err   <= 1'b0;
            day_pulse <= 1'b0;
        end else begin
            state     <= hold ? HOLD : RUN;
            set_err   <= 1'b0;
            day_pulse <= 1'b0;
            // any load, accepted or rejected, swallows the same-cycle tick/inc
            if (set_valid) begin
                if (load_ok) begin
                    horas    <= set_horas;
                    minutos  <= set_minutos;
                    segundos <= set_segundos;
                end else begin
                    set_err <= 1'b1;
                end
            end else if (state == RUN) begin
                if (tick) begin
                    segundos <= s_wrap ? '0 : segundos + SW'(1);
                    if (s_wrap) begin
                        minutos <= m_wrap ? '0 : minutos + MW'(1);
                        if (m_wrap) begin
                            horas <= h_wrap ? '0 : horas + HW'(1);
                            if (h_wrap)
                                day_pulse <= 1'b1;
                        end
                    end
                end
            end else begin
                if (inc_m) begin
                    minutos  <= m_wrap ? '0 : minutos + MW'(1);
                    segundos <= '0;
                end
                if (inc_h)
                    horas <= h_wrap ? '0 : horas + HW'(1);
            end
        end
    end

    always_comb begin
        hora12 = horas;
        pm     = 1'b0;
        if (HOURS_MOD == 24 && horas >= HW'(12)) begin
            hora12 = horas - HW'(12);
            pm     = 1'b1;
        end
        if (hora12 == '0)
            hora12 = HW'(12);
    end

endmodule
